keypad_scanner: RTL and testbench



---
 rtl/keypad_if.sv | 28 ++
 rtl/keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle between the scanner (master) and its consumer.
interface keypad_if;
  logic       col1;
  logic       col2;
  logic       col3;
  logic       row1;
  logic       row2;
  logic       row3;
  logic       row4;
  logic       key_valid;
  logic       key_release;
  logic [3:0] key_code;
  logic       key_held;
  logic       star_level;
  logic       sharp_level;

  modport master (
    input  col1, col2, col3,
    output row1, row2, row3, row4,
    output key_valid, key_release, key_code, key_held, star_level, sharp_level
  );

  modport slave (
    output col1, col2, col3,
    input  row1, row2, row3, row4,
    input  key_valid, key_release, key_code, key_held, star_level, sharp_level
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 keypad row scanner with per-frame ghost rejection, debounce and key events.
// Optional auto-repeat of key_valid while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV        = 500000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input logic      clk,
  input logic      reset,
  keypad_if.master kp
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam int               CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [3:0]       KEY_NONE = 4'hF;

  if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 2 || REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE) begin : g_bad_param
    $error("keypad_scanner: illegal parameter value");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [1:0]       hits_q, hits_d;
  logic [3:0]       fkey_q, fkey_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_release_q, key_release_d;
  logic             key_held_q, key_held_d;
  logic             star_q, star_d;
  logic             sharp_q, sharp_d;

  logic             sample_s, frame_end_s, rep_fire_s;
  logic [2:0]       cols_s, acc_sum_s;
  logic [1:0]       row_hits_s, acc_hits_s;
  logic [3:0]       acc_key_s, frame_code_s;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef KEYPAD_REPEAT_EN
  logic [15:0]      rep_q, rep_d;
`endif

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [2:0] cols);
    logic [3:0] col_n;
    case (cols)
      3'b001:  col_n = 4'd0;
      3'b010:  col_n = 4'd1;
      3'b100:  col_n = 4'd2;
      default: col_n = 4'd0;
    endcase
    if (row != 2'd3) begin
      key_map = {2'b00, row} * 4'd3 + col_n + 4'd1;
    end else begin
      case (col_n)
        4'd0:    key_map = 4'hA;
        4'd1:    key_map = 4'h0;
        default: key_map = 4'hB;
      endcase
    end
  endfunction

  assign cols_s = {kp.col3, kp.col2, kp.col1};

  // Row strobe timing and frame accumulation; hit count saturates at 2 so ghosts read as "many".
  always_comb begin
    sample_s     = (div_q == DIV_LAST);
    frame_end_s  = sample_s && (row_idx_q == 2'd3);
    row_hits_s   = {1'b0, kp.col1} + {1'b0, kp.col2} + {1'b0, kp.col3};
    acc_sum_s    = {1'b0, hits_q} + {1'b0, row_hits_s};
    acc_hits_s   = (acc_sum_s > 3'd2) ? 2'd2 : acc_sum_s[1:0];
    acc_key_s    = (row_hits_s == 2'd1) ? key_map(row_idx_q, cols_s) : fkey_q;
    frame_code_s = (acc_hits_s == 2'd1) ? acc_key_s : KEY_NONE;
    div_d        = sample_s ? '0 : div_q + DIV_W'(1);
    row_idx_d    = sample_s ? row_idx_q + 2'd1 : row_idx_q;
    row_d        = sample_s ? {row_q[2:0], row_q[3]} : row_q;
    if (sample_s) begin
      hits_d = frame_end_s ? 2'd0 : acc_hits_s;
      fkey_d = frame_end_s ? KEY_NONE : acc_key_s;
    end else begin
      hits_d = hits_q;
      fkey_d = fkey_q;
    end
  end

  // Next-state logic, evaluated once per frame at the row4 sample.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    cnt_inc_s  = cnt_q + CNT_W'(1);
    rep_fire_s = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
`endif
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          if (frame_code_s != KEY_NONE) begin
            state_d = PRESS_DB;
            cand_d  = frame_code_s;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end
        PRESS_DB: begin
          if (frame_code_s == cand_q) begin
            cnt_d   = cnt_inc_s;
            state_d = (cnt_inc_s == CNT_DONE) ? HELD : PRESS_DB;
          end else if (frame_code_s == KEY_NONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cand_d = frame_code_s;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: begin
          if (frame_code_s == cand_q) begin
`ifdef KEYPAD_REPEAT_EN
            // Reload so the next hit of REPEAT_DELAY is REPEAT_RATE frames later.
            if (rep_q + 16'd1 == 16'(REPEAT_DELAY)) begin
              rep_fire_s = 1'b1;
              rep_d      = 16'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              rep_d = rep_q + 16'd1;
            end
`endif
          end else begin
            state_d = RELEASE_DB;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_DB: begin
          if (frame_code_s == cand_q) begin
            state_d = HELD;
          end else if (cnt_inc_s == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Registered key event outputs derived from the frame transition.
  always_comb begin
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_code_d    = key_code_q;
    if (frame_end_s) begin
      case (state_q)
        PRESS_DB: begin
          if (frame_code_s == cand_q && cnt_inc_s == CNT_DONE) begin
            key_valid_d = 1'b1;
            key_code_d  = cand_q;
          end else begin
            key_valid_d = 1'b0;
          end
        end
        HELD: begin
          key_valid_d = rep_fire_s;
        end
        RELEASE_DB: begin
          if (frame_code_s != cand_q && cnt_inc_s == CNT_DONE) begin
            key_release_d = 1'b1;
            key_code_d    = KEY_NONE;
          end else begin
            key_release_d = 1'b0;
          end
        end
        default: begin
          key_valid_d = 1'b0;
        end
      endcase
    end else begin
      key_code_d = key_code_q;
    end
    key_held_d = (state_d == HELD) || (state_d == RELEASE_DB);
    star_d     = key_held_d && (key_code_d == 4'hA);
    sharp_d    = key_held_d && (key_code_d == 4'hB);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      row_idx_q     <= 2'd0;
      row_q         <= 4'b0001;
      hits_q        <= 2'd0;
      fkey_q        <= KEY_NONE;
      state_q       <= IDLE;
      cand_q        <= KEY_NONE;
      cnt_q         <= '0;
      key_code_q    <= KEY_NONE;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_held_q    <= 1'b0;
      star_q        <= 1'b0;
      sharp_q       <= 1'b0;
    end else begin
      div_q         <= div_d;
      row_idx_q     <= row_idx_d;
      row_q         <= row_d;
      hits_q        <= hits_d;
      fkey_q        <= fkey_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_held_q    <= key_held_d;
      star_q        <= star_d;
      sharp_q       <= sharp_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Held-frame counter for auto-repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign kp.row1        = row_q[0];
  assign kp.row2        = row_q[1];
  assign kp.row3        = row_q[2];
  assign kp.row4        = row_q[3];
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_held    = key_held_q;
  assign kp.star_level  = star_q;
  assign kp.sharp_level = sharp_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;
  localparam int FRAME = 16;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mask  = 12'd0;  // pressed keys, index = row*3 + col

  int total = 0;
  int bad   = 0;
  int cyc, nvalid, nrel, nboth, rowbad, last_valid_cyc, last_rel_cyc;
  logic [3:0] last_code;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (
    .clk(clk), .reset(reset), .kp(kp)
  );

  always #5 clk = ~clk;

  assign kp.col1 = (kp.row1 & mask[0]) | (kp.row2 & mask[3]) | (kp.row3 & mask[6]) | (kp.row4 & mask[9]);
  assign kp.col2 = (kp.row1 & mask[1]) | (kp.row2 & mask[4]) | (kp.row3 & mask[7]) | (kp.row4 & mask[10]);
  assign kp.col3 = (kp.row1 & mask[2]) | (kp.row2 & mask[5]) | (kp.row3 & mask[8]) | (kp.row4 & mask[11]);

  task automatic clear_counts();
    cyc = 1; nvalid = 0; nrel = 0; nboth = 0; rowbad = 0;
    last_valid_cyc = -1; last_rel_cyc = -1; last_code = 4'hE;
  endtask

  // cyc = 1 is the first cycle of a frame (row1 active, divider at 0).
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (kp.key_valid === 1'b1) begin nvalid++; last_valid_cyc = cyc; last_code = kp.key_code; end
    if (kp.key_release === 1'b1) begin nrel++; last_rel_cyc = cyc; end
    if (kp.key_valid === 1'b1 && kp.key_release === 1'b1) nboth++;
    if (!$onehot({kp.row4, kp.row3, kp.row2, kp.row1})) rowbad++;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FRAME) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    reset = 1'b1; mask = 12'b0000_0001_0000;
    @(posedge clk); @(posedge clk); #1;
    total++; if ({kp.row4, kp.row3, kp.row2, kp.row1} !== 4'b0001) begin bad++; $display("FAIL reset_rows: got %b want 0001", {kp.row4, kp.row3, kp.row2, kp.row1}); end
    total++; if (kp.key_code !== 4'hF) begin bad++; $display("FAIL reset_code: got %h want f", kp.key_code); end
    total++; if ({kp.key_valid, kp.key_release, kp.key_held, kp.star_level, kp.sharp_level} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {kp.key_valid, kp.key_release, kp.key_held, kp.star_level, kp.sharp_level}); end
    mask = 12'd0; reset = 1'b0; clear_counts();
    for (int r = 1; r <= 4; r++) begin
      repeat (4) step();
      total++; if ({kp.row4, kp.row3, kp.row2, kp.row1} !== 4'((r == 4) ? 1 : (1 << r))) begin bad++; $display("FAIL rotate_%0d: got %b at cycle %0d", r, {kp.row4, kp.row3, kp.row2, kp.row1}, cyc); end
    end
    total++; if (rowbad !== 0) begin bad++; $display("FAIL rows_onehot: got %0d bad cycles want 0", rowbad); end
  endtask

  task automatic test_key5();
    do_reset(); mask = 12'b0000_0001_0000;
    run_frames(3);
    total++; if (last_valid_cyc !== 49) begin bad++; $display("FAIL key5_latency: got cycle %0d want 49", last_valid_cyc); end
    total++; if (kp.key_code !== 4'h5 || kp.key_held !== 1'b1) begin bad++; $display("FAIL key5_code: got %h held %b want 5 held 1", kp.key_code, kp.key_held); end
    run_frames(1);
    total++; if (nvalid !== 1) begin bad++; $display("FAIL key5_single: got %0d pulses want 1", nvalid); end
    total++; if (kp.star_level !== 1'b0 || kp.sharp_level !== 1'b0) begin bad++; $display("FAIL key5_levels: got %b%b want 00", kp.star_level, kp.sharp_level); end
  endtask

  task automatic test_star_release();
    do_reset(); mask = 12'b0010_0000_0000;
    run_frames(3);
    total++; if (kp.star_level !== 1'b1 || kp.key_code !== 4'hA) begin bad++; $display("FAIL star_accept: got star %b code %h want 1 a", kp.star_level, kp.key_code); end
    run_frames(1);
    mask = 12'd0;
    run_frames(1);
    total++; if (kp.key_held !== 1'b1 || kp.star_level !== 1'b1 || nrel !== 0) begin bad++; $display("FAIL star_release_db: got held %b star %b rel %0d want 1 1 0", kp.key_held, kp.star_level, nrel); end
    run_frames(2);
    total++; if (nrel !== 1 || last_rel_cyc !== 113) begin bad++; $display("FAIL star_release: got %0d pulses at %0d want 1 at 113", nrel, last_rel_cyc); end
    total++; if (kp.key_code !== 4'hF || kp.key_held !== 1'b0 || kp.star_level !== 1'b0) begin bad++; $display("FAIL star_idle: got code %h held %b star %b want f 0 0", kp.key_code, kp.key_held, kp.star_level); end
    total++; if (nvalid !== 1) begin bad++; $display("FAIL star_valid_count: got %0d want 1", nvalid); end
  endtask

  task automatic test_bounce();
    do_reset(); mask = 12'b0000_0100_0000;
    run_frames(1);
    mask = 12'd0;
    run_frames(1);
    mask = 12'b0000_0100_0000;
    run_frames(2);
    total++; if (nvalid !== 0) begin bad++; $display("FAIL bounce_early: got %0d pulses want 0", nvalid); end
    run_frames(1);
    total++; if (nvalid !== 1 || last_valid_cyc !== 81 || last_code !== 4'h7) begin bad++; $display("FAIL bounce_accept: got %0d at %0d code %h want 1 at 81 code 7", nvalid, last_valid_cyc, last_code); end
  endtask

  task automatic test_ghost();
    do_reset(); mask = 12'b0000_0010_1000;
    run_frames(3);
    mask = 12'b0001_0000_0001;
    run_frames(3);
    total++; if (nvalid !== 0 || kp.key_held !== 1'b0) begin bad++; $display("FAIL ghost_reject: got %0d pulses held %b want 0 0", nvalid, kp.key_held); end
    mask = 12'b0000_0000_0001;
    run_frames(3);
    total++; if (nvalid !== 1 || last_valid_cyc !== 145 || last_code !== 4'h1) begin bad++; $display("FAIL ghost_recover: got %0d at %0d code %h want 1 at 145 code 1", nvalid, last_valid_cyc, last_code); end
  endtask

  task automatic test_back_to_back();
    do_reset(); mask = 12'b0000_0000_0010;
    run_frames(3);
    mask = 12'd0;
    run_frames(1);
    mask = 12'b0000_0000_0010;
    run_frames(1);
    total++; if (kp.key_held !== 1'b1 || nvalid !== 1 || nrel !== 0) begin bad++; $display("FAIL b2b_glitch: got held %b valid %0d rel %0d want 1 1 0", kp.key_held, nvalid, nrel); end
    mask = 12'b0000_0000_0100;
    run_frames(3);
    total++; if (nrel !== 1 || last_rel_cyc !== 129 || kp.key_code !== 4'hF) begin bad++; $display("FAIL b2b_release: got %0d at %0d code %h want 1 at 129 code f", nrel, last_rel_cyc, kp.key_code); end
    run_frames(3);
    total++; if (nvalid !== 2 || last_valid_cyc !== 177 || last_code !== 4'h3) begin bad++; $display("FAIL b2b_second: got %0d at %0d code %h want 2 at 177 code 3", nvalid, last_valid_cyc, last_code); end
    total++; if (nboth !== 0) begin bad++; $display("FAIL b2b_exclusive: got %0d overlapping cycles want 0", nboth); end
  endtask

  task automatic test_repeat();
    int exp_n;
    do_reset(); mask = 12'b0100_0000_0000;
    run_frames(3);
    total++; if (nvalid !== 1 || kp.key_code !== 4'h0) begin bad++; $display("FAIL rep_accept: got %0d code %h want 1 code 0", nvalid, kp.key_code); end
    for (int k = 1; k <= 6; k++) begin
      run_frames(1);
      exp_n = (REP_EN && k >= 2) ? k : 1;
      total++; if (nvalid !== exp_n) begin bad++; $display("FAIL rep_frame_%0d: got %0d pulses want %0d", k, nvalid, exp_n); end
    end
    mask = 12'd0;
    run_frames(4);
    exp_n = REP_EN ? 6 : 1;
    total++; if (nvalid !== exp_n || nrel !== 1 || last_code !== 4'h0) begin bad++; $display("FAIL rep_release: got valid %0d rel %0d code %h want %0d 1 0", nvalid, nrel, last_code, exp_n); end
  endtask

  task automatic test_reset_mid();
    do_reset(); mask = 12'b0000_0001_0000;
    run_frames(2);
    repeat (8) step();
    reset = 1'b1;
    step();
    total++; if ({kp.row4, kp.row3, kp.row2, kp.row1} !== 4'b0001 || kp.key_code !== 4'hF || kp.key_held !== 1'b0) begin bad++; $display("FAIL midreset_state: got rows %b code %h held %b", {kp.row4, kp.row3, kp.row2, kp.row1}, kp.key_code, kp.key_held); end
    reset = 1'b0; clear_counts();
    run_frames(2);
    total++; if (nvalid !== 0) begin bad++; $display("FAIL midreset_count: got %0d pulses want 0", nvalid); end
    run_frames(1);
    total++; if (nvalid !== 1 || last_valid_cyc !== 49) begin bad++; $display("FAIL midreset_accept: got %0d at %0d want 1 at 49", nvalid, last_valid_cyc); end
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    total++; if (nrel !== 0 || kp.key_held !== 1'b0 || kp.key_code !== 4'hF) begin bad++; $display("FAIL heldreset: got rel %0d held %b code %h want 0 0 f", nrel, kp.key_held, kp.key_code); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_key5();
    test_star_release();
    test_bounce();
    test_ghost();
    test_back_to_back();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
